// File: rtl/ex_unidad_riesgos_fwd_pkg.sv
// Shared encodings for the ID-stage hazard/forwarding unit.
// Holds the operand-mux select codes and the stall FSM state type.
package haz_pkg;

    localparam logic [2:0] MUX_REGFILE = 3'b000;
    localparam logic [2:0] MUX_EX_MEM  = 3'b001;
    localparam logic [2:0] MUX_MEM_WB  = 3'b010;
    localparam logic [2:0] MUX_WB_HOLD = 3'b011;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } haz_state_t;

endpackage

// File: rtl/ex_unidad_riesgos_fwd_if.sv
// Pipeline-side bundle of the hazard/forwarding unit (ID operands, producer info, selects, stalls).
// Defining HAZ_PERF_CNT_EN adds the o_cnt_stall / o_cnt_fwd performance counters.
interface ex_unidad_riesgos_fwd_if #(
    parameter int NPORTS  = 2,
    parameter int RNBITS  = 5,
    parameter int MUXBITS = 3
);
    logic                      i_hold;
    logic                      i_flush;
    logic [NPORTS*RNBITS-1:0]  i_id_src;
    logic [NPORTS-1:0]         i_id_uses;
    logic                      i_ID_EX_RegWrite;
    logic                      i_ID_EX_MemRead;
    logic [RNBITS-1:0]         i_ID_EX_Rd;
    logic                      i_EX_MEM_RegWrite;
    logic [RNBITS-1:0]         i_EX_MEM_Rd;
    logic                      i_MEM_WB_RegWrite;
    logic [RNBITS-1:0]         i_MEM_WB_Rd;
    logic [NPORTS*MUXBITS-1:0] o_mux_operandos;
    logic                      o_stall_pc;
    logic                      o_stall_if_id;
    logic                      o_bubble_id_ex;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0]               o_cnt_stall;
    logic [31:0]               o_cnt_fwd;

    modport master (
        output i_hold, i_flush, i_id_src, i_id_uses,
               i_ID_EX_RegWrite, i_ID_EX_MemRead, i_ID_EX_Rd,
               i_EX_MEM_RegWrite, i_EX_MEM_Rd, i_MEM_WB_RegWrite, i_MEM_WB_Rd,
        input  o_mux_operandos, o_stall_pc, o_stall_if_id, o_bubble_id_ex,
               o_cnt_stall, o_cnt_fwd
    );
    modport slave (
        input  i_hold, i_flush, i_id_src, i_id_uses,
               i_ID_EX_RegWrite, i_ID_EX_MemRead, i_ID_EX_Rd,
               i_EX_MEM_RegWrite, i_EX_MEM_Rd, i_MEM_WB_RegWrite, i_MEM_WB_Rd,
        output o_mux_operandos, o_stall_pc, o_stall_if_id, o_bubble_id_ex,
               o_cnt_stall, o_cnt_fwd
    );
`else
    modport master (
        output i_hold, i_flush, i_id_src, i_id_uses,
               i_ID_EX_RegWrite, i_ID_EX_MemRead, i_ID_EX_Rd,
               i_EX_MEM_RegWrite, i_EX_MEM_Rd, i_MEM_WB_RegWrite, i_MEM_WB_Rd,
        input  o_mux_operandos, o_stall_pc, o_stall_if_id, o_bubble_id_ex
    );
    modport slave (
        input  i_hold, i_flush, i_id_src, i_id_uses,
               i_ID_EX_RegWrite, i_ID_EX_MemRead, i_ID_EX_Rd,
               i_EX_MEM_RegWrite, i_EX_MEM_Rd, i_MEM_WB_RegWrite, i_MEM_WB_Rd,
        output o_mux_operandos, o_stall_pc, o_stall_if_id, o_bubble_id_ex
    );
`endif
endinterface

// File: rtl/ex_unidad_riesgos_fwd_sel.sv
// One source operand's forwarding comparator: picks the nearest matching producer
// and flags a match against a load sitting in EX.
module ex_fwd_sel_port
    import haz_pkg::*;
#(
    parameter int RNBITS  = 5,
    parameter int MUXBITS = 3
) (
    input  logic [RNBITS-1:0]  i_src,
    input  logic               i_use,
    input  logic               i_ex_we,
    input  logic               i_ex_load,
    input  logic [RNBITS-1:0]  i_ex_rd,
    input  logic               i_mem_we,
    input  logic [RNBITS-1:0]  i_mem_rd,
    input  logic               i_wb_we,
    input  logic [RNBITS-1:0]  i_wb_rd,
    output logic [MUXBITS-1:0] o_sel,
    output logic               o_load_match
);
    logic w_valid;

    // r0 is hard-wired zero, so a zero source never needs a forwarded value.
    assign w_valid = i_use && (i_src != '0);

    always_comb begin
        o_sel = MUXBITS'(MUX_REGFILE);
        if (w_valid) begin
            if (i_ex_we && (i_ex_rd == i_src))
                o_sel = MUXBITS'(MUX_EX_MEM);
            else if (i_mem_we && (i_mem_rd == i_src))
                o_sel = MUXBITS'(MUX_MEM_WB);
            else if (i_wb_we && (i_wb_rd == i_src))
                o_sel = MUXBITS'(MUX_WB_HOLD);
        end
    end

    assign o_load_match = w_valid && i_ex_we && i_ex_load && (i_ex_rd == i_src);

endmodule

// File: rtl/ex_unidad_riesgos_fwd.sv
// Hazard + forwarding unit between ID and EX: registered per-port operand selects and load-use stall FSM.
// Optional: define HAZ_PERF_CNT_EN for saturating stall/forward performance counters.
module ex_unidad_riesgos_fwd
    import haz_pkg::*;
#(
    parameter int NPORTS   = 2,
    parameter int RNBITS   = 5,
    parameter int MUXBITS  = 3,
    parameter int LOAD_LAT = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    ex_unidad_riesgos_fwd_if.slave bus
);
    // The detection cycle is already the first bubble, so STALL covers only the remaining LOAD_LAT-1.
    localparam haz_state_t HAZ_NEXT = (LOAD_LAT > 1) ? STALL : IDLE;
    localparam logic [2:0] CNT_INIT = (LOAD_LAT > 1) ? 3'(LOAD_LAT - 2) : 3'd0;

    logic [NPORTS*MUXBITS-1:0] w_sel;
    logic [NPORTS*MUXBITS-1:0] w_sel_nxt;
    logic [NPORTS*MUXBITS-1:0] r_sel;
    logic [NPORTS-1:0]         w_load_match;
    haz_state_t                r_state;
    haz_state_t                w_state_nxt;
    logic [2:0]                r_cnt;
    logic [2:0]                w_cnt_nxt;
    logic                      w_flush;
    logic                      w_hazard;
    logic                      w_stall;

    for (genvar k = 0; k < NPORTS; k++) begin : g_port
        ex_fwd_sel_port #(
            .RNBITS  (RNBITS),
            .MUXBITS (MUXBITS)
        ) u_port (
            .i_src        (bus.i_id_src[k*RNBITS +: RNBITS]),
            .i_use        (bus.i_id_uses[k]),
            .i_ex_we      (bus.i_ID_EX_RegWrite),
            .i_ex_load    (bus.i_ID_EX_MemRead),
            .i_ex_rd      (bus.i_ID_EX_Rd),
            .i_mem_we     (bus.i_EX_MEM_RegWrite),
            .i_mem_rd     (bus.i_EX_MEM_Rd),
            .i_wb_we      (bus.i_MEM_WB_RegWrite),
            .i_wb_rd      (bus.i_MEM_WB_Rd),
            .o_sel        (w_sel[k*MUXBITS +: MUXBITS]),
            .o_load_match (w_load_match[k])
        );
    end

    // A held pipeline ignores flush; otherwise flush beats any stall.
    assign w_flush  = bus.i_flush && !bus.i_hold;
    assign w_hazard = (r_state == IDLE) && (|w_load_match);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
            r_sel   <= '0;
        end else if (!bus.i_hold) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_flush) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 3'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hazard) begin
                        w_state_nxt = HAZ_NEXT;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end
                STALL: begin
                    if (r_cnt == 3'd0)
                        w_state_nxt = IDLE;
                    else
                        w_cnt_nxt = r_cnt - 3'd1;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 3'd0;
                end
            endcase
        end
    end

    always_comb begin
        w_stall   = i_rst_n && !w_flush && (w_hazard || (r_state == STALL));
        w_sel_nxt = (w_stall || w_flush) ? '0 : w_sel;
    end

    assign bus.o_mux_operandos = r_sel;
    assign bus.o_stall_pc      = w_stall;
    assign bus.o_stall_if_id   = w_stall;
    assign bus.o_bubble_id_ex  = w_stall;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_cnt_stall;
    logic [31:0] r_cnt_fwd;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt_stall <= '0;
            r_cnt_fwd   <= '0;
        end else if (!bus.i_hold) begin
            if (w_stall && (r_cnt_stall != '1))
                r_cnt_stall <= r_cnt_stall + 32'd1;
            if ((|w_sel_nxt) && (r_cnt_fwd != '1))
                r_cnt_fwd <= r_cnt_fwd + 32'd1;
        end
    end

    assign bus.o_cnt_stall = r_cnt_stall;
    assign bus.o_cnt_fwd   = r_cnt_fwd;
`endif

endmodule

// File: tb/tb_ex_unidad_riesgos_fwd.sv
// Scoreboard bench for ex_unidad_riesgos_fwd: two instances (LOAD_LAT=1 and LOAD_LAT=3) share one stimulus stream.
module tb_ex_unidad_riesgos_fwd;

    typedef struct packed {
        logic [4:0] s0;
        logic [4:0] s1;
        logic [1:0] uses;
        logic       exW;
        logic       exL;
        logic [4:0] exRd;
        logic       memW;
        logic [4:0] memRd;
        logic       wbW;
        logic [4:0] wbRd;
        logic       hold;
        logic       flush;
    } in_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        hold, flush;
    logic [9:0]  src;
    logic [1:0]  uses;
    logic        exW, exL, memW, wbW;
    logic [4:0]  exRd, memRd, wbRd;
    logic [2:0]  stall1, stall3;
    logic [11:0] sb [$];
    int          nChecks = 0;
    int          nFail   = 0;
    in_t         L, M, F, NOP;

    always #5 clk = ~clk;

    ex_unidad_riesgos_fwd_if #(.NPORTS(2), .RNBITS(5), .MUXBITS(3)) if1 ();
    ex_unidad_riesgos_fwd_if #(.NPORTS(2), .RNBITS(5), .MUXBITS(3)) if3 ();

    ex_unidad_riesgos_fwd #(.NPORTS(2), .RNBITS(5), .MUXBITS(3), .LOAD_LAT(1)) dut1 (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .bus     (if1)
    );
    ex_unidad_riesgos_fwd #(.NPORTS(2), .RNBITS(5), .MUXBITS(3), .LOAD_LAT(3)) dut3 (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .bus     (if3)
    );

    assign if1.i_hold = hold;              assign if3.i_hold = hold;
    assign if1.i_flush = flush;            assign if3.i_flush = flush;
    assign if1.i_id_src = src;             assign if3.i_id_src = src;
    assign if1.i_id_uses = uses;           assign if3.i_id_uses = uses;
    assign if1.i_ID_EX_RegWrite = exW;     assign if3.i_ID_EX_RegWrite = exW;
    assign if1.i_ID_EX_MemRead = exL;      assign if3.i_ID_EX_MemRead = exL;
    assign if1.i_ID_EX_Rd = exRd;          assign if3.i_ID_EX_Rd = exRd;
    assign if1.i_EX_MEM_RegWrite = memW;   assign if3.i_EX_MEM_RegWrite = memW;
    assign if1.i_EX_MEM_Rd = memRd;        assign if3.i_EX_MEM_Rd = memRd;
    assign if1.i_MEM_WB_RegWrite = wbW;    assign if3.i_MEM_WB_RegWrite = wbW;
    assign if1.i_MEM_WB_Rd = wbRd;         assign if3.i_MEM_WB_Rd = wbRd;

    assign stall1 = {if1.o_stall_pc, if1.o_stall_if_id, if1.o_bubble_id_ex};
    assign stall3 = {if3.o_stall_pc, if3.o_stall_if_id, if3.o_bubble_id_ex};

    function automatic in_t mkIn(input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] u,
                                 input logic ew, input logic el, input logic [4:0] er,
                                 input logic mw, input logic [4:0] mr,
                                 input logic ww, input logic [4:0] wr,
                                 input logic h, input logic f);
        in_t t;
        t.s0 = s0; t.s1 = s1; t.uses = u;
        t.exW = ew; t.exL = el; t.exRd = er;
        t.memW = mw; t.memRd = mr; t.wbW = ww; t.wbRd = wr;
        t.hold = h; t.flush = f;
        return t;
    endfunction

    task automatic drive(input in_t t);
        src = {t.s1, t.s0}; uses = t.uses;
        exW = t.exW; exL = t.exL; exRd = t.exRd;
        memW = t.memW; memRd = t.memRd; wbW = t.wbW; wbRd = t.wbRd;
        hold = t.hold; flush = t.flush;
    endtask

    task automatic test_reset();
        rstN = 1'b1;
        drive(L);
        #1 rstN = 1'b0;
        #1;
        nChecks++; if (stall1 !== 3'b000) begin nFail++; $display("[TB] FAIL reset stall1: got %b want 000", stall1); end
        nChecks++; if (stall3 !== 3'b000) begin nFail++; $display("[TB] FAIL reset stall3: got %b want 000", stall3); end
        @(posedge clk); #1;
        nChecks++; if (if1.o_mux_operandos !== 6'o00) begin nFail++; $display("[TB] FAIL reset sel1: got %o want 00", if1.o_mux_operandos); end
        nChecks++; if (if3.o_mux_operandos !== 6'o00) begin nFail++; $display("[TB] FAIL reset sel3: got %o want 00", if3.o_mux_operandos); end
        @(negedge clk);
        rstN = 1'b1;
        drive(NOP);
        #1;
        nChecks++; if (stall3 !== 3'b000) begin nFail++; $display("[TB] FAIL reset release stall3: got %b want 000", stall3); end
    endtask

    task automatic test_forwarding();
        in_t         stim [8];
        logic [5:0]  want [8];
        logic [11:0] exp;
        stim[0] = mkIn(5'd8, 5'd0, 2'b01, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);   want[0] = 6'o01;
        stim[1] = mkIn(5'd0, 5'd8, 2'b10, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);   want[1] = 6'o10;
        stim[2] = mkIn(5'd8, 5'd3, 2'b11, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b1, 5'd3, 1'b0, 1'b0);   want[2] = 6'o32;
        stim[3] = mkIn(5'd5, 5'd5, 2'b11, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);   want[3] = 6'o22;
        stim[4] = mkIn(5'd7, 5'd7, 2'b01, 1'b1, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0);   want[4] = 6'o01;
        stim[5] = mkIn(5'd4, 5'd6, 2'b11, 1'b0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 5'd6, 1'b0, 1'b0);   want[5] = 6'o30;
        stim[6] = mkIn(5'd12, 5'd12, 2'b11, 1'b1, 1'b0, 5'd13, 1'b1, 5'd14, 1'b1, 5'd15, 1'b0, 1'b0); want[6] = 6'o00;
        stim[7] = mkIn(5'd5, 5'd8, 2'b11, 1'b1, 1'b0, 5'd8, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);   want[7] = 6'o12;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); drive(stim[i]); #1;
            nChecks++; if (stall1 !== 3'b000) begin nFail++; $display("[TB] FAIL fwd row %0d stall1: got %b want 000", i, stall1); end
            nChecks++; if (stall3 !== 3'b000) begin nFail++; $display("[TB] FAIL fwd row %0d stall3: got %b want 000", i, stall3); end
            sb.push_back({want[i], want[i]});
            @(posedge clk); #1;
            exp = sb.pop_front();
            nChecks++; if (if1.o_mux_operandos !== exp[11:6]) begin nFail++; $display("[TB] FAIL fwd row %0d sel1: got %o want %o", i, if1.o_mux_operandos, exp[11:6]); end
            nChecks++; if (if3.o_mux_operandos !== exp[5:0]) begin nFail++; $display("[TB] FAIL fwd row %0d sel3: got %o want %o", i, if3.o_mux_operandos, exp[5:0]); end
        end
    endtask

    task automatic test_zero_and_unused();
        in_t         stim [3];
        logic [11:0] exp;
        stim[0] = mkIn(5'd0, 5'd0, 2'b11, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        stim[1] = mkIn(5'd9, 5'd9, 2'b00, 1'b1, 1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0);
        stim[2] = mkIn(5'd0, 5'd9, 2'b01, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(stim[i]); #1;
            nChecks++; if (stall1 !== 3'b000) begin nFail++; $display("[TB] FAIL zero row %0d stall1: got %b want 000", i, stall1); end
            nChecks++; if (stall3 !== 3'b000) begin nFail++; $display("[TB] FAIL zero row %0d stall3: got %b want 000", i, stall3); end
            sb.push_back(12'o0000);
            @(posedge clk); #1;
            exp = sb.pop_front();
            nChecks++; if (if1.o_mux_operandos !== exp[11:6]) begin nFail++; $display("[TB] FAIL zero row %0d sel1: got %o want %o", i, if1.o_mux_operandos, exp[11:6]); end
            nChecks++; if (if3.o_mux_operandos !== exp[5:0]) begin nFail++; $display("[TB] FAIL zero row %0d sel3: got %o want %o", i, if3.o_mux_operandos, exp[5:0]); end
        end
    endtask

    // Shared row runner body is repeated per scenario; st = {dut1 stalls, dut3 stalls}.
    task automatic test_load_use();
        in_t         stim [10];
        logic [1:0]  st   [10] = '{2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
        logic [5:0]  w1   [10] = '{6'o00, 6'o20, 6'o20, 6'o20, 6'o00, 6'o00, 6'o00, 6'o00, 6'o20, 6'o00};
        logic [5:0]  w3   [10] = '{6'o00, 6'o00, 6'o00, 6'o20, 6'o00, 6'o00, 6'o00, 6'o00, 6'o20, 6'o00};
        logic [11:0] exp;
        stim = '{L, M, M, M, NOP, L, L, L, M, NOP};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); drive(stim[i]); #1;
            nChecks++; if (stall1 !== {3{st[i][1]}}) begin nFail++; $display("[TB] FAIL loaduse row %0d stall1: got %b want %b", i, stall1, {3{st[i][1]}}); end
            nChecks++; if (stall3 !== {3{st[i][0]}}) begin nFail++; $display("[TB] FAIL loaduse row %0d stall3: got %b want %b", i, stall3, {3{st[i][0]}}); end
            sb.push_back({w1[i], w3[i]});
            @(posedge clk); #1;
            exp = sb.pop_front();
            nChecks++; if (if1.o_mux_operandos !== exp[11:6]) begin nFail++; $display("[TB] FAIL loaduse row %0d sel1: got %o want %o", i, if1.o_mux_operandos, exp[11:6]); end
            nChecks++; if (if3.o_mux_operandos !== exp[5:0]) begin nFail++; $display("[TB] FAIL loaduse row %0d sel3: got %o want %o", i, if3.o_mux_operandos, exp[5:0]); end
        end
    endtask

    task automatic test_flush();
        in_t         stim [5];
        logic [1:0]  st   [5] = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
        logic [5:0]  w1   [5] = '{6'o00, 6'o00, 6'o20, 6'o00, 6'o00};
        logic [5:0]  w3   [5] = '{6'o00, 6'o00, 6'o20, 6'o00, 6'o00};
        logic [11:0] exp;
        stim = '{L, M, M, L, NOP};
        stim[1].flush = 1'b1;
        stim[3].flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); drive(stim[i]); #1;
            nChecks++; if (stall1 !== {3{st[i][1]}}) begin nFail++; $display("[TB] FAIL flush row %0d stall1: got %b want %b", i, stall1, {3{st[i][1]}}); end
            nChecks++; if (stall3 !== {3{st[i][0]}}) begin nFail++; $display("[TB] FAIL flush row %0d stall3: got %b want %b", i, stall3, {3{st[i][0]}}); end
            sb.push_back({w1[i], w3[i]});
            @(posedge clk); #1;
            exp = sb.pop_front();
            nChecks++; if (if1.o_mux_operandos !== exp[11:6]) begin nFail++; $display("[TB] FAIL flush row %0d sel1: got %o want %o", i, if1.o_mux_operandos, exp[11:6]); end
            nChecks++; if (if3.o_mux_operandos !== exp[5:0]) begin nFail++; $display("[TB] FAIL flush row %0d sel3: got %o want %o", i, if3.o_mux_operandos, exp[5:0]); end
        end
    endtask

    task automatic test_hold();
        in_t         stim [9];
        logic [1:0]  st   [9] = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
        logic [5:0]  w1   [9] = '{6'o00, 6'o20, 6'o20, 6'o20, 6'o20, 6'o20, 6'o20, 6'o20, 6'o00};
        logic [5:0]  w3   [9] = '{6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o20, 6'o00};
        logic [11:0] exp;
        stim = '{L, M, F, F, F, F, M, M, NOP};
        stim[3].flush = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); drive(stim[i]); #1;
            nChecks++; if (stall1 !== {3{st[i][1]}}) begin nFail++; $display("[TB] FAIL hold row %0d stall1: got %b want %b", i, stall1, {3{st[i][1]}}); end
            nChecks++; if (stall3 !== {3{st[i][0]}}) begin nFail++; $display("[TB] FAIL hold row %0d stall3: got %b want %b", i, stall3, {3{st[i][0]}}); end
            sb.push_back({w1[i], w3[i]});
            @(posedge clk); #1;
            exp = sb.pop_front();
            nChecks++; if (if1.o_mux_operandos !== exp[11:6]) begin nFail++; $display("[TB] FAIL hold row %0d sel1: got %o want %o", i, if1.o_mux_operandos, exp[11:6]); end
            nChecks++; if (if3.o_mux_operandos !== exp[5:0]) begin nFail++; $display("[TB] FAIL hold row %0d sel3: got %o want %o", i, if3.o_mux_operandos, exp[5:0]); end
        end
    endtask

    task automatic test_reset_mid_stall();
        in_t         stim [2];
        logic [1:0]  st   [2] = '{2'b11, 2'b01};
        logic [5:0]  w1   [2] = '{6'o00, 6'o20};
        logic [11:0] exp;
        stim = '{L, M};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); drive(stim[i]); #1;
            nChecks++; if (stall1 !== {3{st[i][1]}}) begin nFail++; $display("[TB] FAIL midrst row %0d stall1: got %b want %b", i, stall1, {3{st[i][1]}}); end
            nChecks++; if (stall3 !== {3{st[i][0]}}) begin nFail++; $display("[TB] FAIL midrst row %0d stall3: got %b want %b", i, stall3, {3{st[i][0]}}); end
            sb.push_back({w1[i], 6'o00});
            @(posedge clk); #1;
            exp = sb.pop_front();
            nChecks++; if (if1.o_mux_operandos !== exp[11:6]) begin nFail++; $display("[TB] FAIL midrst row %0d sel1: got %o want %o", i, if1.o_mux_operandos, exp[11:6]); end
            nChecks++; if (if3.o_mux_operandos !== exp[5:0]) begin nFail++; $display("[TB] FAIL midrst row %0d sel3: got %o want %o", i, if3.o_mux_operandos, exp[5:0]); end
        end
        @(negedge clk);
        drive(L);
        rstN = 1'b0;
        #1;
        nChecks++; if (stall1 !== 3'b000) begin nFail++; $display("[TB] FAIL midrst async stall1: got %b want 000", stall1); end
        nChecks++; if (stall3 !== 3'b000) begin nFail++; $display("[TB] FAIL midrst async stall3: got %b want 000", stall3); end
        nChecks++; if (if1.o_mux_operandos !== 6'o00) begin nFail++; $display("[TB] FAIL midrst async sel1: got %o want 00", if1.o_mux_operandos); end
        nChecks++; if (if3.o_mux_operandos !== 6'o00) begin nFail++; $display("[TB] FAIL midrst async sel3: got %o want 00", if3.o_mux_operandos); end
        @(negedge clk);
        rstN = 1'b1;
        drive(NOP);
        #1;
        nChecks++; if (stall3 !== 3'b000) begin nFail++; $display("[TB] FAIL midrst idle stall3: got %b want 000", stall3); end
        @(posedge clk); #1;
        nChecks++; if (if3.o_mux_operandos !== 6'o00) begin nFail++; $display("[TB] FAIL midrst idle sel3: got %o want 00", if3.o_mux_operandos); end
    endtask

    initial begin
        L   = mkIn(5'd0, 5'd9, 2'b10, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        M   = mkIn(5'd0, 5'd9, 2'b10, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0);
        F   = mkIn(5'd8, 5'd9, 2'b11, 1'b1, 1'b0, 5'd8, 1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 1'b0);
        NOP = '0;
        $display("[TB] starting hazard/forwarding unit bench");
        test_reset();
        test_forwarding();
        test_zero_and_unused();
        test_load_use();
        test_flush();
        test_hold();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
